// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared definitions for the raster timing generator.
//                - Axis phase encoding (ACTIVE -> FP -> SYNC -> BP -> ACTIVE)
//                - Timing constants for 640x480@60 (default) and 1280x720@60
//                - Helpers for derived line/frame totals and width checks
//  Revision    : 1.0  initial release
// ============================================================================
package video_pkg;

  // Phase of one raster axis, in the order the axis walks through them.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_e;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_H_POL    = 1'b0;
  localparam bit VGA_V_POL    = 1'b0;

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs
  localparam int HD_H_ACTIVE  = 1280;
  localparam int HD_H_FP      = 110;
  localparam int HD_H_SYNC    = 40;
  localparam int HD_H_BP      = 220;
  localparam int HD_V_ACTIVE  = 720;
  localparam int HD_V_FP      = 5;
  localparam int HD_V_SYNC    = 5;
  localparam int HD_V_BP      = 20;
  localparam bit HD_H_POL     = 1'b1;
  localparam bit HD_V_POL     = 1'b1;

  // Total period of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // True when a counter of 'w' bits can hold every value 0..total-1.
  function automatic bit fits_width(input int total, input int w);
    return longint'(total - 1) < (longint'(1) << w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_axis.sv
`default_nettype none
// ============================================================================
//  Module      : timing_axis
//  Description : One raster axis: a four-phase FSM (ACTIVE/FP/SYNC/BP) with an
//                in-phase counter and an absolute position counter.
//  Ports       : clk, rst_n     clock, asynchronous active-low reset
//                step           advance one position (or start from idle)
//                clear          force to idle at position 0 (wins over step)
//                position       registered current position
//                active, sync   decode of the state loaded on the coming edge
//                wrap           the coming edge loads position 0 from a run or
//                               from idle (start of a new line/frame)
//  Revision    : 1.0  initial release
// ============================================================================
module timing_axis
  import video_pkg::*;
#(
  parameter int LEN_ACTIVE = 640,
  parameter int LEN_FP     = 16,
  parameter int LEN_SYNC   = 96,
  parameter int LEN_BP     = 48,
  parameter int CW         = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] position,
  output logic          active,
  output logic          sync,
  output logic          wrap
);

  localparam logic [1:0] S_ACTIVE = ACTIVE;
  localparam logic [1:0] S_FP     = FP;
  localparam logic [1:0] S_SYNC   = SYNC;
  localparam logic [1:0] S_BP     = BP;

  logic [1:0]    r_phase;
  logic [1:0]    w_phase_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_pos_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic [CW-1:0] w_phase_last;
  logic          w_end_of_phase;
  logic          w_end_of_axis;
  logic          w_wrap;

  // Last in-phase count of the current phase.
  always_comb begin
    w_phase_last = CW'(LEN_ACTIVE - 1);
    case (r_phase)
      S_ACTIVE: w_phase_last = CW'(LEN_ACTIVE - 1);
      S_FP:     w_phase_last = CW'(LEN_FP - 1);
      S_SYNC:   w_phase_last = CW'(LEN_SYNC - 1);
      S_BP:     w_phase_last = CW'(LEN_BP - 1);
      default:  w_phase_last = CW'(LEN_ACTIVE - 1);
    endcase
  end

  assign w_end_of_phase = (r_cnt == w_phase_last);
  assign w_end_of_axis  = (r_phase == S_BP) && w_end_of_phase;

  // r_valid distinguishes "idle, parked at 0" from "running, showing 0": the
  // first step out of idle presents position 0 instead of advancing past it.
  assign w_wrap = step && !clear && (!r_valid || w_end_of_axis);

  always_comb begin
    w_valid_nxt = r_valid;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_pos_nxt   = r_pos;
    if (clear) begin
      w_valid_nxt = 1'b0;
      w_phase_nxt = S_ACTIVE;
      w_cnt_nxt   = '0;
      w_pos_nxt   = '0;
    end else if (w_wrap) begin
      w_valid_nxt = 1'b1;
      w_phase_nxt = S_ACTIVE;
      w_cnt_nxt   = '0;
      w_pos_nxt   = '0;
    end else if (step) begin
      w_pos_nxt = r_pos + CW'(1);
      if (w_end_of_phase) begin
        w_cnt_nxt = '0;
        case (r_phase)
          S_ACTIVE: w_phase_nxt = S_FP;
          S_FP:     w_phase_nxt = S_SYNC;
          S_SYNC:   w_phase_nxt = S_BP;
          default:  w_phase_nxt = S_ACTIVE;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_phase <= S_ACTIVE;
      r_cnt   <= '0;
      r_pos   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  // Lookahead decodes: the top registers them on the same edge that loads
  // r_pos, so every output lines up with the position it describes.
  assign position = r_pos;
  assign active   = w_valid_nxt && (w_phase_nxt == S_ACTIVE);
  assign sync     = w_valid_nxt && (w_phase_nxt == S_SYNC);
  assign wrap     = w_wrap;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing generator for the DVI/HDMI output path.
//                Horizontal axis steps every pixel clock while enabled; the
//                vertical axis steps on each horizontal wrap. All outputs are
//                registered on the edge that loads (sx, sy).
//  Ports       : clk          pixel clock (clk_pix)
//                rst_n        asynchronous active-low reset
//                en           run enable (clk_pix_locked); low forces idle
//                hsync/vsync  syncs, active level H_POL / V_POL
//                de           visible-pixel data enable
//                sx, sy       current pixel position
//                line_start   one-cycle pulse at sx == 0
//                frame_start  one-cycle pulse at sx == 0, sy == 0
//  Revision    : 1.0  initial release
// ============================================================================
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = VGA_H_POL,
  parameter bit V_POL    = VGA_V_POL,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h_len
    $error("video_timing_gen: every horizontal phase length must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v_len
    $error("video_timing_gen: every vertical phase length must be >= 1");
  end
  if (!fits_width(H_TOTAL, CW)) begin : g_bad_h_width
    $error("video_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (!fits_width(V_TOTAL, CW)) begin : g_bad_v_width
    $error("video_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end

  logic w_clear;
  logic w_h_active;
  logic w_h_sync;
  logic w_h_wrap;
  logic w_v_active;
  logic w_v_sync;
  logic w_v_wrap;

  // Dropping en parks both axes at 0, so re-enabling always starts a fresh
  // frame rather than resuming a partial one.
  assign w_clear = !en;

  timing_axis #(
    .LEN_ACTIVE (H_ACTIVE),
    .LEN_FP     (H_FP),
    .LEN_SYNC   (H_SYNC),
    .LEN_BP     (H_BP),
    .CW         (CW)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (en),
    .clear    (w_clear),
    .position (sx),
    .active   (w_h_active),
    .sync     (w_h_sync),
    .wrap     (w_h_wrap)
  );

  // The vertical axis also steps on the very first horizontal "wrap" out of
  // idle, which is what brings it from idle to a valid line 0.
  timing_axis #(
    .LEN_ACTIVE (V_ACTIVE),
    .LEN_FP     (V_FP),
    .LEN_SYNC   (V_SYNC),
    .LEN_BP     (V_BP),
    .CW         (CW)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (w_h_wrap),
    .clear    (w_clear),
    .position (sy),
    .active   (w_v_active),
    .sync     (w_v_sync),
    .wrap     (w_v_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= w_h_active && w_v_active;
      hsync       <= w_h_sync ? H_POL : ~H_POL;
      vsync       <= w_v_sync ? V_POL : ~V_POL;
      line_start  <= w_h_wrap;
      frame_start <= w_v_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen: 640x480, 720p and a
//                tiny raster share clock, reset and enable. A counter-based
//                reference model feeds per-instance scoreboards; vector tables
//                and hand sequences cover the corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tcfg_t;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [11:0] sx;
    logic [11:0] sy;
  } obs_t;

  typedef struct {
    bit run;
    int sx;
    int sy;
  } mstate_t;

  typedef struct {
    int         cyc;
    logic [11:0] sx, sy;
    logic       de, hs, vs, ls, fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic vga_hs, vga_vs, vga_de, vga_ls, vga_fs;
  logic [11:0] vga_sx, vga_sy;
  logic hd_hs, hd_vs, hd_de, hd_ls, hd_fs;
  logic [11:0] hd_sx, hd_sy;
  logic sm_hs, sm_vs, sm_de, sm_ls, sm_fs;
  logic [3:0] sm_sx, sm_sy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_timing_gen u_vga (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(vga_hs), .vsync(vga_vs), .de(vga_de), .sx(vga_sx), .sy(vga_sy),
    .line_start(vga_ls), .frame_start(vga_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720), .V_FP(5), .V_SYNC(5), .V_BP(20),
    .H_POL(1'b1), .V_POL(1'b1), .CW(12)
  ) u_hd (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hd_hs), .vsync(hd_vs), .de(hd_de), .sx(hd_sx), .sy(hd_sy),
    .line_start(hd_ls), .frame_start(hd_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b0), .CW(4)
  ) u_sm (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(sm_hs), .vsync(sm_vs), .de(sm_de), .sx(sm_sx), .sy(sm_sy),
    .line_start(sm_ls), .frame_start(sm_fs)
  );

  localparam tcfg_t CFG_VGA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam tcfg_t CFG_HD  = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
  localparam tcfg_t CFG_SM  = '{4, 2, 3, 2, 3, 1, 2, 2, 1'b1, 1'b0};

  // ---------------- reference model ----------------
  function automatic mstate_t model_step(input tcfg_t c, input mstate_t s, input logic e);
    mstate_t n;
    n = s;
    if (!e) begin
      n.run = 1'b0; n.sx = 0; n.sy = 0;
    end else if (!s.run) begin
      n.run = 1'b1; n.sx = 0; n.sy = 0;
    end else begin
      n.sx = s.sx + 1;
      if (n.sx == c.ha + c.hf + c.hs + c.hb) begin
        n.sx = 0;
        n.sy = s.sy + 1;
        if (n.sy == c.va + c.vf + c.vs + c.vb) n.sy = 0;
      end
    end
    return n;
  endfunction

  function automatic obs_t model_out(input tcfg_t c, input mstate_t s);
    obs_t o;
    o.de = 1'b0; o.hs = ~c.hp; o.vs = ~c.vp; o.ls = 1'b0; o.fs = 1'b0;
    o.sx = 12'(s.sx); o.sy = 12'(s.sy);
    if (s.run) begin
      o.de = (s.sx < c.ha) && (s.sy < c.va);
      if (s.sx >= c.ha + c.hf && s.sx < c.ha + c.hf + c.hs) o.hs = c.hp;
      if (s.sy >= c.va + c.vf && s.sy < c.va + c.vf + c.vs) o.vs = c.vp;
      o.ls = (s.sx == 0);
      o.fs = (s.sx == 0) && (s.sy == 0);
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  mstate_t st_vga, st_hd, st_sm;
  obs_t    q_vga[$];
  obs_t    q_hd[$];
  obs_t    q_sm[$];

  always @(posedge clk or negedge rst_n) begin : p_model
    mstate_t n_v, n_h, n_s;
    if (!rst_n) begin
      n_v = '{1'b0, 0, 0}; n_h = n_v; n_s = n_v;
      q_vga.delete(); q_hd.delete(); q_sm.delete();
    end else begin
      n_v = model_step(CFG_VGA, st_vga, en);
      n_h = model_step(CFG_HD, st_hd, en);
      n_s = model_step(CFG_SM, st_sm, en);
    end
    st_vga <= n_v;
    st_hd  <= n_h;
    st_sm  <= n_s;
    q_vga.push_back(model_out(CFG_VGA, n_v));
    q_hd.push_back(model_out(CFG_HD, n_h));
    q_sm.push_back(model_out(CFG_SM, n_s));
  end

  task automatic sb_cmp(input string nm, input obs_t act, input obs_t exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL sb_%s @%0t: got de=%b hs=%b vs=%b ls=%b fs=%b sx=%0d sy=%0d, expected de=%b hs=%b vs=%b ls=%b fs=%b sx=%0d sy=%0d",
               nm, $time, act.de, act.hs, act.vs, act.ls, act.fs, act.sx, act.sy,
               exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.sx, exp.sy);
    end
  endtask

  always @(negedge clk) begin : p_score
    obs_t e;
    if (q_vga.size() > 0) begin
      e = q_vga.pop_front();
      sb_cmp("vga", '{vga_de, vga_hs, vga_vs, vga_ls, vga_fs, vga_sx, vga_sy}, e);
    end
    if (q_hd.size() > 0) begin
      e = q_hd.pop_front();
      sb_cmp("hd", '{hd_de, hd_hs, hd_vs, hd_ls, hd_fs, hd_sx, hd_sy}, e);
    end
    if (q_sm.size() > 0) begin
      e = q_sm.pop_front();
      sb_cmp("small", '{sm_de, sm_hs, sm_vs, sm_ls, sm_fs, {8'd0, sm_sx}, {8'd0, sm_sy}}, e);
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    vec_t vecs[11];
    int   edges;
    int   guard;
    int   ls_last, hd_ls_last, fs_last, de_run, hs_run;

    // edge k after reset release presents sx=(k-1)%800, sy=(k-1)/800
    vecs[0]  = '{1,    12'd0,   12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2,    12'd1,   12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{640,  12'd639, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{641,  12'd640, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{656,  12'd655, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{657,  12'd656, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{752,  12'd751, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{753,  12'd752, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{800,  12'd799, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{801,  12'd0,   12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1601, 12'd0,   12'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vga_de", vga_de, 0);
    chk("rst_vga_hsync", vga_hs, 1);
    chk("rst_vga_vsync", vga_vs, 1);
    chk("rst_vga_sx", vga_sx, 0);
    chk("rst_vga_fs", vga_fs, 0);
    chk("rst_hd_hsync", hd_hs, 0);
    chk("rst_hd_vsync", hd_vs, 0);

    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 11; i++) begin
      while (edges < vecs[i].cyc) begin
        @(posedge clk);
        edges++;
      end
      @(negedge clk);
      n_assert++;
      if ({vga_sx, vga_sy, vga_de, vga_hs, vga_vs, vga_ls, vga_fs} !==
          {vecs[i].sx, vecs[i].sy, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs}) begin
        n_fail++;
        $display("FAIL vec%0d edge %0d: got sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                 i, vecs[i].cyc, vga_sx, vga_sy, vga_de, vga_hs, vga_vs, vga_ls, vga_fs,
                 vecs[i].sx, vecs[i].sy, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs);
      end
    end

    // en drop mid-line
    guard = 0;
    while (!(vga_sx == 12'd300 && vga_sy == 12'd2) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_sx300_reached", guard < 5000, 1);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_de", vga_de, 0);
    chk("endrop_hsync", vga_hs, 1);
    chk("endrop_vsync", vga_vs, 1);
    chk("endrop_sx", vga_sx, 0);
    chk("endrop_sy", vga_sy, 0);
    chk("endrop_ls", vga_ls, 0);
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_sx", vga_sx, 0);
    chk("reen_sy", vga_sy, 0);
    chk("reen_fs", vga_fs, 1);
    chk("reen_ls", vga_ls, 1);
    chk("reen_de", vga_de, 1);

    // asynchronous reset mid-line
    guard = 0;
    while (vga_sx != 12'd700 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_sx700_reached", guard < 5000, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sx", vga_sx, 0);
    chk("arst_sy", vga_sy, 0);
    chk("arst_hsync", vga_hs, 1);
    chk("arst_de", vga_de, 0);
    chk("arst_ls", vga_ls, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // free run: periods and pulse widths
    ls_last = -1; hd_ls_last = -1; fs_last = -1; de_run = 0; hs_run = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("restart_sx", vga_sx, 0);
        chk("restart_sy", vga_sy, 0);
        chk("restart_fs", vga_fs, 1);
      end
      if (vga_ls) begin
        if (ls_last >= 0) chk("vga_line_period", k - ls_last, 800);
        ls_last = k;
      end
      if (hd_ls) begin
        if (hd_ls_last >= 0) chk("hd_line_period", k - hd_ls_last, 1650);
        hd_ls_last = k;
      end
      if (sm_fs) begin
        if (fs_last >= 0) chk("small_frame_period", k - fs_last, 88);
        fs_last = k;
      end
      if (vga_de) de_run++;
      else if (de_run != 0) begin
        chk("vga_de_len", de_run, 640);
        de_run = 0;
      end
      if (!vga_hs) hs_run++;
      else if (hs_run != 0) begin
        chk("vga_hsync_len", hs_run, 96);
        hs_run = 0;
      end
      if (hd_sx == 12'd1389) chk("hd_hsync_1389", hd_hs, 0);
      if (hd_sx == 12'd1390) chk("hd_hsync_1390", hd_hs, 1);
      if (hd_sx == 12'd1429) chk("hd_hsync_1429", hd_hs, 1);
      if (hd_sx == 12'd1430) chk("hd_hsync_1430", hd_hs, 0);
      if (hd_sx == 12'd0 && k > 0) chk("hd_sy_after_wrap", hd_sy, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
